// File: rtl/branch_fwd_pkg.sv
// Shared types and helpers for the branch-operand forwarding tracker.
// A slot records one in-flight destination write in the shadow pipeline.
package branch_fwd_pkg;

  // Slot addresses are stored at this fixed width; ADDR_W must not exceed it.
  localparam int MAX_ADDR_W = 8;
  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                  we;
    logic [MAX_ADDR_W-1:0] addr;
    logic                  is_load;
  } slot_t;

  function automatic int fwd_sel_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fwd_slot_pipe.sv
// Shadow shift register of destination writes: slot0=EX, slot1=MEM, slot2=WB, ...
// The whole register freezes on hold; a flushed or rejected push enters as a bubble.
module fwd_slot_pipe
  import branch_fwd_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  input  logic                    flush,
  input  logic                    push,
  input  slot_t                   push_slot,
  output slot_t [DEPTH-1:0]       slots
);

  always_ff @(posedge clk) begin
    if (rst) begin
      slots <= '0;
    end else if (!hold) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        slots[k] <= slots[k-1];
      end
      slots[0] <= (push && !flush) ? push_slot : '0;
    end
  end

endmodule

// File: rtl/branch_fwd_tracker.sv
// ID-stage branch operand forwarding and hazard unit with its own shadow pipeline
// of in-flight writes and a saturating branch-stall counter.
module branch_fwd_tracker
  import branch_fwd_pkg::*;
#(
  parameter  int NUM_SRC    = 2,
  parameter  int ADDR_W     = 5,
  parameter  int DEPTH      = 3,
  parameter  int LOAD_READY = 2,
  parameter  int CNT_W      = 16,
  localparam int SEL_W      = fwd_sel_w(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic                      id_is_branch,
  input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      id_reg_write,
  input  logic [ADDR_W-1:0]         id_dest_addr,
  input  logic                      id_is_load,
  input  logic                      pipe_hold,
  input  logic                      flush,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      branch_stall,
  output logic [CNT_W-1:0]          stall_count
);

  slot_t [DEPTH-1:0] slots;
  slot_t             push_slot;
  logic              check_en;
  logic [NUM_SRC-1:0] op_stall;

  assign push_slot = '{we: id_reg_write, addr: MAX_ADDR_W'(id_dest_addr), is_load: id_is_load};
  assign check_en  = id_valid && id_is_branch;

  fwd_slot_pipe #(.DEPTH(DEPTH)) u_slot_pipe (
    .clk       (clk),
    .rst       (rst),
    .hold      (pipe_hold),
    .flush     (flush),
    .push      (id_valid && !branch_stall),
    .push_slot (push_slot),
    .slots     (slots)
  );

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [MAX_ADDR_W-1:0] src;
    logic                  hit;
    logic                  hit_load;
    logic [SEL_W-1:0]      hit_k;
    logic                  match;

    assign src = MAX_ADDR_W'(id_src_addr[i*ADDR_W +: ADDR_W]);

    // Scan oldest to youngest so the youngest matching slot is the one kept.
    always_comb begin
      hit      = 1'b0;
      hit_load = 1'b0;
      hit_k    = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (slots[k].we && (slots[k].addr == src)) begin
          hit      = 1'b1;
          hit_load = slots[k].is_load;
          hit_k    = SEL_W'(k);
        end
      end
    end

    assign match       = check_en && id_src_used[i] && (src != '0) && hit;
    assign op_stall[i] = match && ((hit_k == '0) ||
                                   (hit_load && (hit_k < SEL_W'(LOAD_READY))));
    assign fwd_sel[i*SEL_W +: SEL_W] = match ? hit_k : SEL_W'(FWD_SEL_RF);
  end

  assign branch_stall = |op_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (branch_stall && !pipe_hold && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_fwd_tracker.sv
// Bench for branch_fwd_tracker: a default instance and a DEPTH=4/NUM_SRC=3/CNT_W=3
// variant share stimulus; expected outputs go through a scoreboard queue.
module tb_branch_fwd_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic        id_is_branch = 1'b0;
  logic [14:0] src_bus = '0;
  logic [2:0]  used = '0;
  logic        rw = 1'b0;
  logic [4:0]  dest = '0;
  logic        ld = 1'b0;
  logic        hold = 1'b0;
  logic        fl = 1'b0;

  logic [3:0]  fwd_sel;
  logic        branch_stall;
  logic [15:0] stall_count;
  logic [5:0]  fwd_sel_v;
  logic        branch_stall_v;
  logic [2:0]  stall_count_v;

  int total = 0;
  int bad   = 0;
  logic use_v = 1'b0;

  typedef struct {
    logic [5:0]  sel;
    logic        st;
    logic [15:0] cnt;
    logic        var_dut;
    string       tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  branch_fwd_tracker dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_is_branch (id_is_branch),
    .id_src_addr  (src_bus[9:0]),
    .id_src_used  (used[1:0]),
    .id_reg_write (rw),
    .id_dest_addr (dest),
    .id_is_load   (ld),
    .pipe_hold    (hold),
    .flush        (fl),
    .fwd_sel      (fwd_sel),
    .branch_stall (branch_stall),
    .stall_count  (stall_count)
  );

  branch_fwd_tracker #(.NUM_SRC(3), .DEPTH(4), .LOAD_READY(2), .CNT_W(3)) dut_v (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_is_branch (id_is_branch),
    .id_src_addr  (src_bus),
    .id_src_used  (used),
    .id_reg_write (rw),
    .id_dest_addr (dest),
    .id_is_load   (ld),
    .pipe_hold    (hold),
    .flush        (fl),
    .fwd_sel      (fwd_sel_v),
    .branch_stall (branch_stall_v),
    .stall_count  (stall_count_v)
  );

  function automatic logic [14:0] s3(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [15:0] sat7(input int x);
    return (x > 7) ? 16'd7 : 16'(x);
  endfunction

  // One ID cycle: drive, queue the expectation, compare at the falling edge, then clock.
  task automatic cyc(input string tag, input logic r, input logic v, input logic br,
                     input logic [14:0] src, input logic [2:0] u, input logic w,
                     input logic [4:0] d, input logic l, input logic h, input logic f,
                     input logic [5:0] esel, input logic est, input logic [15:0] ecnt);
    exp_t e;
    exp_t got;
    rst = r; id_valid = v; id_is_branch = br; src_bus = src; used = u;
    rw = w; dest = d; ld = l; hold = h; fl = f;
    e.sel = esel; e.st = est; e.cnt = ecnt; e.var_dut = use_v; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    if (!got.var_dut) begin
      total += 3;
      if (fwd_sel !== got.sel[3:0]) begin
        bad++; $display("FAIL %s fwd_sel got=%h exp=%h", got.tag, fwd_sel, got.sel[3:0]);
      end
      if (branch_stall !== got.st) begin
        bad++; $display("FAIL %s branch_stall got=%b exp=%b", got.tag, branch_stall, got.st);
      end
      if (stall_count !== got.cnt) begin
        bad++; $display("FAIL %s stall_count got=%0d exp=%0d", got.tag, stall_count, got.cnt);
      end
    end else begin
      total += 3;
      if (fwd_sel_v !== got.sel) begin
        bad++; $display("FAIL %s fwd_sel_v got=%h exp=%h", got.tag, fwd_sel_v, got.sel);
      end
      if (branch_stall_v !== got.st) begin
        bad++; $display("FAIL %s branch_stall_v got=%b exp=%b", got.tag, branch_stall_v, got.st);
      end
      if (stall_count_v !== got.cnt[2:0]) begin
        bad++; $display("FAIL %s stall_count_v got=%0d exp=%0d", got.tag, stall_count_v, got.cnt[2:0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; id_valid = 0; id_is_branch = 0; src_bus = '0; used = '0;
    rw = 0; dest = '0; ld = 0; hold = 0; fl = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    use_v = 0;
    apply_reset();
    cyc("rst_idle", 0,0,0, '0, 3'b000, 0,0,0,0,0, 6'h00,0,0);
    cyc("rst_branch", 0,1,1, s3(3,4,0), 3'b011, 0,0,0,0,0, 6'h00,0,0);
    use_v = 1;
    cyc("rst_idle_v", 0,0,0, '0, 3'b000, 0,0,0,0,0, 6'h00,0,0);
    use_v = 0;
  endtask

  task automatic test_alu();
    use_v = 0;
    apply_reset();
    cyc("alu_add",   0,1,0, '0, 3'b000, 1,5,0,0,0, 6'h00,0,0);
    cyc("alu_stall", 0,1,1, s3(5,0,0), 3'b011, 0,0,0,0,0, 6'h00,1,0);
    cyc("alu_fwd",   0,1,1, s3(5,0,0), 3'b011, 0,0,0,0,0, 6'h01,0,1);
  endtask

  task automatic test_load();
    use_v = 0;
    apply_reset();
    cyc("ld_lw",     0,1,0, '0, 3'b000, 1,7,1,0,0, 6'h00,0,0);
    cyc("ld_stall0", 0,1,1, s3(7,6,0), 3'b011, 0,0,0,0,0, 6'h00,1,0);
    cyc("ld_stall1", 0,1,1, s3(7,6,0), 3'b011, 0,0,0,0,0, 6'h01,1,1);
    cyc("ld_fwd_wb", 0,1,1, s3(7,6,0), 3'b011, 0,0,0,0,0, 6'h02,0,2);
  endtask

  task automatic test_youngest();
    use_v = 0;
    apply_reset();
    cyc("yw_add_a", 0,1,0, '0, 3'b000, 1,8,0,0,0, 6'h00,0,0);
    cyc("yw_add_b", 0,1,0, '0, 3'b000, 1,8,0,0,0, 6'h00,0,0);
    cyc("yw_other", 0,1,0, '0, 3'b000, 1,9,0,0,0, 6'h00,0,0);
    cyc("yw_bne",   0,1,1, s3(8,8,0), 3'b001, 0,0,0,0,0, 6'h01,0,0);
  endtask

  task automatic test_hold_flush();
    use_v = 0;
    apply_reset();
    cyc("hf_lw",      0,1,0, '0, 3'b000, 1,10,1,0,0, 6'h00,0,0);
    cyc("hf_stall0",  0,1,1, s3(10,0,0), 3'b001, 0,0,0,0,0, 6'h00,1,0);
    for (int i = 0; i < 3; i++)
      cyc("hf_hold",  0,1,1, s3(10,0,0), 3'b001, 0,0,0,1,0, 6'h01,1,1);
    cyc("hf_release", 0,1,1, s3(10,0,0), 3'b001, 0,0,0,0,0, 6'h01,1,1);
    cyc("hf_fwd",     0,1,1, s3(10,0,0), 3'b001, 0,0,0,0,0, 6'h02,0,2);
    cyc("hf_flushed", 0,1,0, '0, 3'b000, 1,11,0,0,1, 6'h00,0,2);
    cyc("hf_beq_fl",  0,1,1, s3(11,0,0), 3'b001, 0,0,0,0,0, 6'h00,0,2);
    cyc("hf_add13",   0,1,0, '0, 3'b000, 1,13,0,0,0, 6'h00,0,2);
    cyc("hf_stall_fl",0,1,1, s3(13,0,0), 3'b001, 0,0,0,0,1, 6'h00,1,2);
    cyc("hf_fwd13",   0,1,1, s3(13,0,0), 3'b001, 0,0,0,0,0, 6'h01,0,3);
  endtask

  task automatic test_mid_reset();
    use_v = 0;
    apply_reset();
    cyc("mr_add",   0,1,0, '0, 3'b000, 1,5,0,0,0, 6'h00,0,0);
    cyc("mr_stall", 1,1,1, s3(5,0,0), 3'b011, 0,0,0,0,0, 6'h00,1,0);
    cyc("mr_clear", 0,1,1, s3(5,0,0), 3'b011, 0,0,0,0,0, 6'h00,0,0);
  endtask

  task automatic test_variant();
    use_v = 1;
    apply_reset();
    cyc("v_add20", 0,1,0, '0, 3'b000, 1,20,0,0,0, 6'h00,0,0);
    for (int i = 0; i < 3; i++)
      cyc("v_nop", 0,0,0, '0, 3'b000, 0,0,0,0,0, 6'h00,0,0);
    cyc("v_slot3",  0,1,1, s3(20,0,0), 3'b111, 0,0,0,0,0, 6'h03,0,0);
    cyc("v_add_r0", 0,1,0, '0, 3'b000, 1,0,0,0,0, 6'h00,0,0);
    cyc("v_beq_r0", 0,1,1, s3(0,0,0), 3'b111, 0,0,0,0,0, 6'h00,0,0);
    cyc("v_add20b", 0,1,0, '0, 3'b000, 1,20,0,0,0, 6'h00,0,0);
    cyc("v_nop2",   0,0,0, '0, 3'b000, 0,0,0,0,0, 6'h00,0,0);
    cyc("v_op2",    0,1,1, s3(0,0,20), 3'b111, 0,0,0,0,0, 6'h10,0,0);
    for (int i = 0; i < 5; i++) begin
      cyc("v_sat_lw", 0,1,0, '0, 3'b000, 1,21,1,0,0, 6'h00,0,sat7(2*i));
      cyc("v_sat_s0", 0,1,1, s3(21,0,0), 3'b001, 0,0,0,0,0, 6'h00,1,sat7(2*i));
      cyc("v_sat_s1", 0,1,1, s3(21,0,0), 3'b001, 0,0,0,0,0, 6'h01,1,sat7(2*i+1));
      cyc("v_sat_fw", 0,1,1, s3(21,0,0), 3'b001, 0,0,0,0,0, 6'h02,0,sat7(2*i+2));
    end
    use_v = 0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_alu();
    test_load();
    test_youngest();
    test_hold_flush();
    test_mid_reset();
    test_variant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
